// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter slice.
// Contents:
//   - default widths for the address/data path and the port-1 burst limit
//   - FSM state encoding (IDLE / ISSUE / RD_WAIT)
//   - requester ids PORT0 (MIPS CPU) and PORT1 (debug/loader master)
//   - helper that sizes the burst counter for a given burst limit
package mem_bus_arbiter_pkg;

    localparam int ADDR_W_DFLT    = 7;
    localparam int DATA_W_DFLT    = 32;
    localparam int MAX_BURST_DFLT = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RD_WAIT = 2'd2
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // The counter only ever has to reach MAX_BURST-1; keep at least one bit.
    function automatic int burst_cnt_w(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin selector with port-1 burst lock.
// Ports:
//   reqs       in  2      request vector, bit n = port n
//   rr_last    in  1      port that won the previous grant
//   lock       in  1      port 1 asks to keep the bus for back-to-back grants
//   burst_cnt  in  CNT_W  locked re-grants already given to port 1
//   any_req    out 1      at least one port is requesting
//   winner     out 1      selected port (only meaningful when any_req)
//   burst_next out CNT_W  burst counter value to store if this pick is taken
module rr_pick2
    import mem_bus_arbiter_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DFLT,
    parameter int CNT_W     = burst_cnt_w(MAX_BURST_DFLT)
) (
    input  logic [1:0]       reqs,
    input  logic             rr_last,
    input  logic             lock,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic             any_req,
    output logic             winner,
    output logic [CNT_W-1:0] burst_next
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_BURST - 1);

    always_comb begin
        any_req    = |reqs;
        winner     = PORT0;
        burst_next = '0;
        // A locked re-grant overrides port 0 until LIMIT re-grants have been
        // made; after that the plain round-robin below hands the bus to port 0.
        if ((rr_last == PORT1) && lock && reqs[1] && (burst_cnt < LIMIT)) begin
            winner     = PORT1;
            burst_next = burst_cnt + CNT_W'(1);
        end else if (reqs == 2'b11) begin
            winner = ~rr_last;
        end else if (reqs[1]) begin
            winner = PORT1;
        end else begin
            winner = PORT0;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single-port 128x32 synchronous Memory between
// the MIPS CPU (port 0) and the debug/loader master (port 1).
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   pN_req/we/addr/wdata        requester N transaction, held until pN_gnt
//   pN_gnt                      1-cycle pulse while the transaction is issued
//   pN_rvalid, pN_rdata         read completion pulse and held read data
//   p1_lock                     port 1 burst request
//   mem_cs/we/addr/wdata        Memory control and write data
//   mem_wdata_oe                enable for the top-level Mem_Bus driver
//   mem_rdata                   Mem_Bus as seen by the arbiter
// Per transaction: IDLE (select + latch) -> ISSUE (cs, gnt) -> RD_WAIT for
// reads (capture rdata, pulse rvalid) -> IDLE. All outputs are registered.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DFLT,
    parameter int DATA_W    = DATA_W_DFLT,
    parameter int MAX_BURST = MAX_BURST_DFLT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    input  logic              p1_lock,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wdata_oe,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = burst_cnt_w(MAX_BURST);

    arb_state_t        state, state_nx;
    logic              sel;        // port owning the in-flight transaction
    logic              rr_last;
    logic [CNT_W-1:0]  burst_cnt;

    logic              any_req, winner;
    logic [CNT_W-1:0]  burst_next;
    logic              latch_en;
    logic              pick_we;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_wdata;

    logic [1:0]        gnt_nx, rvalid_nx;
    logic              cs_nx, we_nx;

    rr_pick2 #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_pick (
        .reqs       ({p1_req, p0_req}),
        .rr_last    (rr_last),
        .lock       (p1_lock),
        .burst_cnt  (burst_cnt),
        .any_req    (any_req),
        .winner     (winner),
        .burst_next (burst_next)
    );

    assign latch_en   = (state == ST_IDLE) && any_req;
    assign pick_we    = (winner == PORT1) ? p1_we    : p0_we;
    assign pick_addr  = (winner == PORT1) ? p1_addr  : p0_addr;
    assign pick_wdata = (winner == PORT1) ? p1_wdata : p0_wdata;

    // ---- state register ----
    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // ---- next state and next registered outputs ----
    always_comb begin
        state_nx  = state;
        gnt_nx    = 2'b00;
        rvalid_nx = 2'b00;
        cs_nx     = 1'b0;
        we_nx     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nx       = ST_ISSUE;
                    cs_nx          = 1'b1;
                    we_nx          = pick_we;
                    gnt_nx[winner] = 1'b1;
                end
            end
            // mem_we still holds the latched direction during ISSUE.
            ST_ISSUE:   state_nx = mem_we ? ST_IDLE : ST_RD_WAIT;
            ST_RD_WAIT: begin
                state_nx          = ST_IDLE;
                rvalid_nx[sel]    = 1'b1;
            end
            default:    state_nx = ST_IDLE;
        endcase
    end

    // ---- registered outputs, transaction latch, arbitration history ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            sel       <= PORT0;
            rr_last   <= PORT1;
            burst_cnt <= '0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            {p1_gnt, p0_gnt}       <= gnt_nx;
            {p1_rvalid, p0_rvalid} <= rvalid_nx;
            mem_cs                 <= cs_nx;
            mem_we                 <= we_nx;
            // Address and owner stay frozen from selection through RD_WAIT.
            if (latch_en) begin
                mem_addr  <= pick_addr;
                sel       <= winner;
                rr_last   <= winner;
                burst_cnt <= burst_next;
            end
            if (state == ST_RD_WAIT) begin
                if (sel == PORT1) p1_rdata <= mem_rdata;
                else              p0_rdata <= mem_rdata;
            end
        end
    end

    // Write data is only driven onto the bus under mem_wdata_oe, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (latch_en) mem_wdata <= pick_wdata;
    end

    assign mem_wdata_oe = mem_cs & mem_we;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: table of single transactions plus
// hand-written sequences for reset, contention, burst lock and reset mid-read.
module tb_mem_bus_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [6:0]  p0_addr;
    logic [31:0] p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_lock;
    logic [6:0]  p1_addr;
    logic [31:0] p1_wdata, p1_rdata;
    logic        mem_cs, mem_we, mem_wdata_oe;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    mem_bus_arbiter #(.ADDR_W(7), .DATA_W(32), .MAX_BURST(8)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .p0_req       (p0_req),
        .p0_we        (p0_we),
        .p0_addr      (p0_addr),
        .p0_wdata     (p0_wdata),
        .p0_gnt       (p0_gnt),
        .p0_rvalid    (p0_rvalid),
        .p0_rdata     (p0_rdata),
        .p1_req       (p1_req),
        .p1_we        (p1_we),
        .p1_addr      (p1_addr),
        .p1_wdata     (p1_wdata),
        .p1_gnt       (p1_gnt),
        .p1_rvalid    (p1_rvalid),
        .p1_rdata     (p1_rdata),
        .p1_lock      (p1_lock),
        .mem_cs       (mem_cs),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wdata_oe (mem_wdata_oe),
        .mem_rdata    (mem_rdata)
    );

    // Synchronous 128x32 memory model; Mem_Bus carries write data under oe,
    // otherwise the registered read word.
    logic [31:0] mem_arr [0:127];
    logic [31:0] mem_q;
    logic        mem_init = 1'b1;

    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem_arr[i] <= 32'h0;
            mem_arr[5] <= 32'h0000_0006;
        end else if (mem_cs) begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            else        mem_q <= mem_arr[mem_addr];
        end
    end
    assign mem_rdata = mem_wdata_oe ? mem_wdata : mem_q;

    typedef struct {
        logic        port;
        logic        we;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] exp_rd0, exp_rd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_port(input logic port, input logic req, input logic we,
                              input logic [6:0] addr, input logic [31:0] wdata);
        if (port) begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    // Counts rising edges until the port's gnt (kind=0) or rvalid (kind=1)
    // is seen; 99 means it never came within the budget.
    task automatic wait_for(input logic port, input logic kind, output int lat);
        logic hit;
        lat = 0;
        hit = 1'b0;
        while (!hit && lat < 8) begin
            @(posedge CLK); #1;
            lat++;
            hit = kind ? (port ? p1_rvalid : p0_rvalid) : (port ? p1_gnt : p0_gnt);
        end
        if (!hit) lat = 99;
    endtask

    task automatic do_xfer(input int idx, input vec_t v);
        int lat;
        @(posedge CLK); #1;
        drive_port(v.port, 1'b1, v.we, v.addr, v.wdata);
        wait_for(v.port, 1'b0, lat);
        check($sformatf("v%0d_gnt_latency", idx), lat, 1);
        check($sformatf("v%0d_other_gnt", idx), v.port ? p0_gnt : p1_gnt, 0);
        check($sformatf("v%0d_cs", idx), mem_cs, 1);
        check($sformatf("v%0d_we", idx), mem_we, v.we);
        check($sformatf("v%0d_addr", idx), mem_addr, v.addr);
        check($sformatf("v%0d_oe", idx), mem_wdata_oe, v.we);
        if (v.we) check($sformatf("v%0d_wdata", idx), mem_wdata, v.wdata);
        drive_port(v.port, 1'b0, 1'b0, 7'h0, 32'h0);
        if (!v.we) begin
            wait_for(v.port, 1'b1, lat);
            check($sformatf("v%0d_rvalid_latency", idx), lat, 2);
            check($sformatf("v%0d_rdata", idx), v.port ? p1_rdata : p0_rdata, v.exp_rdata);
            if (v.port) exp_rd1 = v.exp_rdata;
            else        exp_rd0 = v.exp_rdata;
            check($sformatf("v%0d_other_rvalid", idx), v.port ? p0_rvalid : p1_rvalid, 0);
            check($sformatf("v%0d_other_rdata_held", idx), v.port ? p0_rdata : p1_rdata,
                  v.port ? exp_rd0 : exp_rd1);
        end else begin
            @(posedge CLK); #1;
            check($sformatf("v%0d_cs_after_write", idx), mem_cs, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic gseq [$];

        vecs[0] = '{port: 1'b0, we: 1'b0, addr: 7'h05, wdata: 32'h0,         exp_rdata: 32'h0000_0006};
        vecs[1] = '{port: 1'b1, we: 1'b1, addr: 7'h10, wdata: 32'h0000_0012, exp_rdata: 32'h0};
        vecs[2] = '{port: 1'b0, we: 1'b0, addr: 7'h10, wdata: 32'h0,         exp_rdata: 32'h0000_0012};
        vecs[3] = '{port: 1'b1, we: 1'b0, addr: 7'h10, wdata: 32'h0,         exp_rdata: 32'h0000_0012};
        vecs[4] = '{port: 1'b0, we: 1'b1, addr: 7'h7F, wdata: 32'hDEAD_BEEF, exp_rdata: 32'h0};
        vecs[5] = '{port: 1'b1, we: 1'b0, addr: 7'h7F, wdata: 32'h0,         exp_rdata: 32'hDEAD_BEEF};
        vecs[6] = '{port: 1'b1, we: 1'b1, addr: 7'h00, wdata: 32'hA5A5_A5A5, exp_rdata: 32'h0};
        vecs[7] = '{port: 1'b0, we: 1'b0, addr: 7'h00, wdata: 32'h0,         exp_rdata: 32'hA5A5_A5A5};

        // Reset with both ports requesting reads.
        RST = 1'b1;
        p1_lock = 1'b0;
        drive_port(1'b0, 1'b1, 1'b0, 7'h05, 32'h0);
        drive_port(1'b1, 1'b1, 1'b0, 7'h10, 32'h0);
        @(posedge CLK); #1;
        mem_init = 1'b0;
        for (int c = 0; c < 2; c++) begin
            check($sformatf("rst%0d_gnt", c), {p1_gnt, p0_gnt}, 0);
            check($sformatf("rst%0d_cs", c), mem_cs, 0);
            check($sformatf("rst%0d_rvalid", c), {p1_rvalid, p0_rvalid}, 0);
            check($sformatf("rst%0d_addr", c), mem_addr, 0);
            check($sformatf("rst%0d_rdata", c), p0_rdata | p1_rdata, 0);
            if (c == 0) begin @(posedge CLK); #1; end
        end
        RST = 1'b0;
        @(posedge CLK); #1;
        check("first_grant_p0", p0_gnt, 1);
        check("first_grant_not_p1", p1_gnt, 0);
        check("first_grant_addr", mem_addr, 7'h05);
        drive_port(1'b0, 1'b0, 1'b0, 7'h0, 32'h0);
        drive_port(1'b1, 1'b0, 1'b0, 7'h0, 32'h0);
        wait_for(1'b0, 1'b1, lat);
        check("first_read_rvalid_latency", lat, 2);
        check("first_read_rdata", p0_rdata, 32'h0000_0006);
        exp_rd0 = 32'h0000_0006;
        exp_rd1 = 32'h0;

        // Single transactions from the table.
        for (int i = 0; i < 8; i++) do_xfer(i, vecs[i]);

        // Contention: both ports read continuously, no lock. Last winner was p0.
        @(posedge CLK); #1;
        drive_port(1'b0, 1'b1, 1'b0, 7'h05, 32'h0);
        drive_port(1'b1, 1'b1, 1'b0, 7'h10, 32'h0);
        for (int c = 0; c < 40 && gseq.size() < 6; c++) begin
            @(posedge CLK); #1;
            check("rr_gnt_onehot", p0_gnt & p1_gnt, 0);
            check("rr_rvalid_onehot", p0_rvalid & p1_rvalid, 0);
            if (p0_gnt) gseq.push_back(1'b0);
            if (p1_gnt) gseq.push_back(1'b1);
        end
        drive_port(1'b0, 1'b0, 1'b0, 7'h0, 32'h0);
        drive_port(1'b1, 1'b0, 1'b0, 7'h0, 32'h0);
        check("rr_grant_count", gseq.size(), 6);
        for (int i = 0; i < gseq.size(); i++)
            check($sformatf("rr_seq%0d", i), gseq[i], (i % 2 == 0) ? 1 : 0);
        repeat (4) @(posedge CLK);
        #1;
        check("rr_p0_rdata", p0_rdata, 32'h0000_0006);
        check("rr_p1_rdata", p1_rdata, 32'h0000_0012);

        // Reset while a p0 read sits in RD_WAIT.
        @(posedge CLK); #1;
        drive_port(1'b0, 1'b1, 1'b0, 7'h10, 32'h0);
        wait_for(1'b0, 1'b0, lat);
        check("midrd_gnt_latency", lat, 1);
        drive_port(1'b0, 1'b0, 1'b0, 7'h0, 32'h0);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        check("midrd_rvalid", {p1_rvalid, p0_rvalid}, 0);
        check("midrd_p0_rdata", p0_rdata, 0);
        check("midrd_p1_rdata", p1_rdata, 0);
        check("midrd_cs", mem_cs, 0);
        check("midrd_addr", mem_addr, 0);
        check("midrd_gnt", {p1_gnt, p0_gnt}, 0);
        @(posedge CLK); #1;
        check("midrd_rvalid_later", {p1_rvalid, p0_rvalid}, 0);
        RST = 1'b0;

        // Burst lock: p0 wins first, then p1 locks against a requesting p0.
        p1_lock = 1'b1;
        drive_port(1'b0, 1'b1, 1'b0, 7'h05, 32'h0);
        wait_for(1'b0, 1'b0, lat);
        check("lock_pre_p0_gnt_latency", lat, 1);
        drive_port(1'b1, 1'b1, 1'b0, 7'h10, 32'h0);
        gseq.delete();
        for (int c = 0; c < 80 && gseq.size() < 10; c++) begin
            @(posedge CLK); #1;
            check("lock_gnt_onehot", p0_gnt & p1_gnt, 0);
            if (p0_gnt) gseq.push_back(1'b0);
            if (p1_gnt) gseq.push_back(1'b1);
        end
        drive_port(1'b0, 1'b0, 1'b0, 7'h0, 32'h0);
        drive_port(1'b1, 1'b0, 1'b0, 7'h0, 32'h0);
        p1_lock = 1'b0;
        check("lock_grant_count", gseq.size(), 10);
        for (int i = 0; i < gseq.size(); i++)
            check($sformatf("lock_seq%0d", i), gseq[i], (i == 8) ? 0 : 1);
        repeat (4) @(posedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
